// File: rtl/clint_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : clint_timer                                                     |
// | Purpose  : APB core-local interruptor: prescaled 64-bit mtime, per-hart    |
// |            mtimecmp/timer interrupt, optional msip (macro CLINT_SWI_EN).   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module clint_timer #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_HARTS  = 1,
    parameter int                    PRESCALE   = 1000,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h11000000
) (
    input  logic                  pclk,
    input  logic                  prst,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pdata,
    output logic [DATA_WIDTH-1:0] prdata,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [3:0]            pstb,
    output logic                  pready,
    output logic                  perr,
    output logic [NUM_HARTS-1:0]  timer_interrupt,
    output logic [NUM_HARTS-1:0]  soft_interrupt
);

    localparam int                    c_pcnt_w    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_pcnt_w-1:0]   c_pcnt_last = c_pcnt_w'(PRESCALE - 1);
    localparam int                    c_hart_w    = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

    logic [c_pcnt_w-1:0]   r_pcnt;
    logic [63:0]           r_mtime;
    logic [63:0]           r_mtimecmp [NUM_HARTS];
    logic                  r_pready;
    logic                  r_perr;
    logic [DATA_WIDTH-1:0] r_prdata;
    logic [NUM_HARTS-1:0]  r_tip;

    logic                  w_access;
    logic                  w_wr;
    logic                  w_tick;
    logic                  w_base_hit;
    logic [15:0]           w_off;
    logic                  w_sel_msip;
    logic                  w_sel_cmp;
    logic                  w_sel_mt_lo;
    logic                  w_sel_mt_hi;
    logic                  w_mapped;
    logic [c_hart_w-1:0]   w_cmp_hart;
    logic                  w_cmp_hi;
    logic [DATA_WIDTH-1:0] w_rdata;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  stb);
        logic [31:0] res;
        res = old_v;
        for (int k = 0; k < 4; k++) begin
            if (stb[k]) res[8*k +: 8] = new_v[8*k +: 8];
        end
        return res;
    endfunction

    // Only the access-phase edge of a transfer commits; pready masks the held phase.
    assign w_access   = psel && penable && !r_pready;
    assign w_wr       = w_access && pwrite;
    assign w_tick     = (r_pcnt == c_pcnt_last);
    assign w_base_hit = (paddr[ADDR_WIDTH-1:16] == BASE_ADDR[ADDR_WIDTH-1:16]);
    assign w_off      = paddr[15:0];
    assign w_cmp_hart = w_off[c_hart_w+2:3];
    assign w_cmp_hi   = w_off[2];

`ifdef CLINT_SWI_EN
    logic [NUM_HARTS-1:0] r_msip;
    logic [NUM_HARTS-1:0] r_sip;
    logic [c_hart_w-1:0]  w_msip_hart;

    assign w_msip_hart = w_off[c_hart_w+1:2];
`endif

    always_comb begin
        w_sel_msip  = 1'b0;
        w_sel_cmp   = 1'b0;
        w_sel_mt_lo = 1'b0;
        w_sel_mt_hi = 1'b0;
        if (w_base_hit && (w_off[1:0] == 2'b00)) begin
            if (w_off == 16'hBFF8) begin
                w_sel_mt_lo = 1'b1;
            end else if (w_off == 16'hBFFC) begin
                w_sel_mt_hi = 1'b1;
            end else if (w_off[15:14] == 2'b01) begin
                w_sel_cmp = (int'(w_off[13:3]) < NUM_HARTS);
            end
`ifdef CLINT_SWI_EN
            else if (w_off[15:14] == 2'b00) begin
                w_sel_msip = (int'(w_off[13:2]) < NUM_HARTS);
            end
`endif
        end
    end

    assign w_mapped = w_sel_msip || w_sel_cmp || w_sel_mt_lo || w_sel_mt_hi;

    always_comb begin
        w_rdata = '0;
        if (w_sel_mt_lo) begin
            w_rdata = r_mtime[31:0];
        end else if (w_sel_mt_hi) begin
            w_rdata = r_mtime[63:32];
        end else if (w_sel_cmp) begin
            w_rdata = w_cmp_hi ? r_mtimecmp[w_cmp_hart][63:32] : r_mtimecmp[w_cmp_hart][31:0];
        end
`ifdef CLINT_SWI_EN
        else if (w_sel_msip) begin
            w_rdata = {31'd0, r_msip[w_msip_hart]};
        end
`endif
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            r_pcnt   <= '0;
            r_mtime  <= '0;
            r_pready <= 1'b0;
            r_perr   <= 1'b0;
            r_prdata <= '0;
            for (int h = 0; h < NUM_HARTS; h++) r_mtimecmp[h] <= '1;
        end else begin
            r_pcnt   <= w_tick ? '0 : r_pcnt + c_pcnt_w'(1);
            r_pready <= w_access;
            if (w_access) begin
                r_perr   <= !w_mapped;
                r_prdata <= (w_mapped && !pwrite) ? w_rdata : '0;
            end
            // A strobed mtime write overrides the tick increment for that edge.
            if (w_wr && w_sel_mt_lo && (pstb != 4'b0000)) begin
                r_mtime[31:0] <= f_merge(r_mtime[31:0], pdata, pstb);
            end else if (w_wr && w_sel_mt_hi && (pstb != 4'b0000)) begin
                r_mtime[63:32] <= f_merge(r_mtime[63:32], pdata, pstb);
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end
            if (w_wr && w_sel_cmp) begin
                if (w_cmp_hi)
                    r_mtimecmp[w_cmp_hart][63:32] <= f_merge(r_mtimecmp[w_cmp_hart][63:32], pdata, pstb);
                else
                    r_mtimecmp[w_cmp_hart][31:0]  <= f_merge(r_mtimecmp[w_cmp_hart][31:0], pdata, pstb);
            end
        end
    end

    generate
        for (genvar h = 0; h < NUM_HARTS; h++) begin : g_tip
            always_ff @(posedge pclk) begin
                if (prst) r_tip[h] <= 1'b0;
                else      r_tip[h] <= (r_mtime >= r_mtimecmp[h]);
            end
        end
    endgenerate

`ifdef CLINT_SWI_EN
    always_ff @(posedge pclk) begin
        if (prst) begin
            r_msip <= '0;
            r_sip  <= '0;
        end else begin
            r_sip <= r_msip;
            if (w_wr && w_sel_msip && pstb[0]) r_msip[w_msip_hart] <= pdata[0];
        end
    end

    assign soft_interrupt = r_sip;
`else
    assign soft_interrupt = '0;
`endif

    assign prdata          = r_prdata;
    assign pready          = r_pready;
    assign perr            = r_perr;
    assign timer_interrupt = r_tip;

endmodule
`default_nettype wire

// File: tb/tb_clint_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_clint_timer                                                  |
// | Purpose  : Scoreboard bench for clint_timer, NUM_HARTS=2, PRESCALE=4.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_clint_timer;

    localparam int          NH    = 2;
    localparam int          PS    = 4;
    localparam logic [31:0] BASE  = 32'h1100_0000;

    logic        pclk = 1'b0;
    logic        prst;
    logic [31:0] paddr;
    logic [31:0] pdata;
    logic [31:0] prdata;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [3:0]  pstb;
    logic        pready;
    logic        perr;
    logic [NH-1:0] timer_interrupt;
    logic [NH-1:0] soft_interrupt;

    clint_timer #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_HARTS  (NH),
        .PRESCALE   (PS),
        .BASE_ADDR  (BASE)
    ) dut (
        .pclk            (pclk),
        .prst            (prst),
        .paddr           (paddr),
        .pdata           (pdata),
        .prdata          (prdata),
        .psel            (psel),
        .penable         (penable),
        .pwrite          (pwrite),
        .pstb            (pstb),
        .pready          (pready),
        .perr            (perr),
        .timer_interrupt (timer_interrupt),
        .soft_interrupt  (soft_interrupt)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        wr;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    logic started = 1'b0;

    // Reference state: time is derived from the edge count since reset.
    logic [63:0]   m_mtime;
    logic [63:0]   m_cmp [NH];
    logic [NH-1:0] m_msip;
    logic [NH-1:0] m_tip;
    logic [NH-1:0] m_sip;
    logic          m_pready;
    longint        m_edge;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = s[k] ? n[8*k +: 8] : o[8*k +: 8];
        return r;
    endfunction

    // 0 unmapped, 1 msip, 2 mtimecmp, 3 mtime
    function automatic int decode(input logic [31:0] a, output int hart, output logic hi);
        longint off;
        off  = longint'({32'd0, a}) - longint'({32'd0, BASE});
        hart = 0;
        hi   = 1'b0;
        if (off < 0 || off >= 65536 || (off % 4) != 0) return 0;
        if (off == 'hBFF8) return 3;
        if (off == 'hBFFC) begin hi = 1'b1; return 3; end
        if (off >= 'h4000 && off < 'h4000 + 8 * NH) begin
            hart = int'((off - 'h4000) / 8);
            hi   = ((off % 8) == 4);
            return 2;
        end
`ifdef CLINT_SWI_EN
        if (off < 4 * NH) begin hart = int'(off / 4); return 1; end
`endif
        return 0;
    endfunction

    always @(posedge pclk) begin
        logic [63:0]   nt;
        logic [NH-1:0] ntip;
        logic [NH-1:0] nsip;
        logic          acc;
        logic          wrote;
        logic          hi;
        int            kind;
        int            hart;
        exp_t          e;
        if (prst) begin
            m_mtime  = '0;
            for (int h = 0; h < NH; h++) m_cmp[h] = '1;
            m_msip   = '0;
            m_tip    = '0;
            m_sip    = '0;
            m_pready = 1'b0;
            m_edge   = 0;
        end else begin
            m_edge++;
            acc = psel && penable && !m_pready;
            for (int h = 0; h < NH; h++) ntip[h] = (m_mtime >= m_cmp[h]);
`ifdef CLINT_SWI_EN
            nsip = m_msip;
`else
            nsip = '0;
`endif
            nt    = m_mtime;
            wrote = 1'b0;
            if (acc) begin
                kind   = decode(paddr, hart, hi);
                e.wr   = pwrite;
                e.err  = (kind == 0);
                e.data = '0;
                if (!pwrite) begin
                    case (kind)
                        1: e.data = {31'd0, m_msip[hart]};
                        2: e.data = hi ? m_cmp[hart][63:32] : m_cmp[hart][31:0];
                        3: e.data = hi ? m_mtime[63:32] : m_mtime[31:0];
                        default: e.data = '0;
                    endcase
                end else if (pstb != 4'b0000) begin
                    case (kind)
                        1: if (pstb[0]) m_msip[hart] = pdata[0];
                        2: if (hi) m_cmp[hart][63:32] = merge(m_cmp[hart][63:32], pdata, pstb);
                           else    m_cmp[hart][31:0]  = merge(m_cmp[hart][31:0], pdata, pstb);
                        3: begin
                            wrote = 1'b1;
                            if (hi) nt[63:32] = merge(nt[63:32], pdata, pstb);
                            else    nt[31:0]  = merge(nt[31:0], pdata, pstb);
                        end
                        default: ;
                    endcase
                end
                q.push_back(e);
            end
            if (!wrote && (m_edge % PS) == 0) nt = nt + 64'd1;
            m_mtime  = nt;
            m_tip    = ntip;
            m_sip    = nsip;
            m_pready = acc;
        end
    end

    // Monitor: compares outputs each cycle and pops one expectation per pready.
    always @(negedge pclk) begin
        exp_t e;
        if (started && !prst) begin
            checks++;
            if (timer_interrupt !== m_tip) begin
                errors++;
                $display("FAIL timer_interrupt t=%0t got=%b exp=%b", $time, timer_interrupt, m_tip);
            end
            checks++;
            if (soft_interrupt !== m_sip) begin
                errors++;
                $display("FAIL soft_interrupt t=%0t got=%b exp=%b", $time, soft_interrupt, m_sip);
            end
            if (pready === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL pready_unexpected t=%0t got=1 exp=0", $time);
                end else begin
                    e = q.pop_front();
                    if (perr !== e.err) begin
                        errors++;
                        $display("FAIL perr t=%0t addr=%h got=%b exp=%b", $time, paddr, perr, e.err);
                    end
                    if (!e.wr) begin
                        checks++;
                        if (prdata !== e.data) begin
                            errors++;
                            $display("FAIL prdata t=%0t addr=%h got=%h exp=%h", $time, paddr, prdata, e.data);
                        end
                    end
                end
            end else if (q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL pready_missing t=%0t got=%b exp=1", $time, pready);
                void'(q.pop_front());
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic apb(input logic [31:0] off, input logic wr, input logic [31:0] d,
                       input logic [3:0] s, input logic absolute = 1'b0);
        bit seen;
        @(negedge pclk);
        paddr   = absolute ? off : BASE + off;
        pwrite  = wr;
        pdata   = d;
        pstb    = s;
        psel    = 1'b1;
        penable = 1'b0;
        @(negedge pclk);
        penable = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge pclk);
            if (pready === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL pready_timeout addr=%h got=0 exp=1", paddr);
        end
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    logic [31:0] offs [13];

    initial begin
        offs = '{32'h0, 32'h4, 32'h8, 32'h4000, 32'h4004, 32'h4008, 32'h400C,
                 32'h4010, 32'hBFF8, 32'hBFFC, 32'h8000, 32'hBFF9, 32'h1_0000};
        prst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pdata = '0; pstb = '0;
        repeat (2) @(negedge pclk);
        chk("reset_pready", {63'd0, pready}, 64'd0);
        chk("reset_perr", {63'd0, perr}, 64'd0);
        chk("reset_prdata", {32'd0, prdata}, 64'd0);
        chk("reset_tip", {62'd0, timer_interrupt}, 64'd0);
        chk("reset_sip", {62'd0, soft_interrupt}, 64'd0);
        prst    = 1'b0;
        started = 1'b1;
        repeat (40) @(negedge pclk);
        apb(32'hBFF8, 1'b0, 0, 4'h0);
        apb(32'hBFFC, 1'b0, 0, 4'h0);

        // Compare channel 1 against a small mtime
        apb(32'h4008, 1'b1, 32'd30, 4'hF);
        apb(32'h400C, 1'b1, 32'd0, 4'hF);
        repeat (10) apb(32'hBFF8, 1'b0, 0, 4'h0);

        // Partial strobes, unmapped and misaligned accesses
        apb(32'h4000, 1'b1, 32'hAABBCCDD, 4'b0101);
        apb(32'h4000, 1'b0, 0, 4'h0);
        apb(32'h4004, 1'b0, 0, 4'h0);
        apb(32'h8000, 1'b0, 0, 4'h0);
        apb(32'h8000, 1'b1, 32'h1234, 4'hF);
        apb(32'h4010, 1'b0, 0, 4'h0);
        apb(32'h4010, 1'b1, 32'h0, 4'hF);
        apb(32'h4002, 1'b0, 0, 4'h0);
        apb(32'h1200_BFF8, 1'b0, 0, 4'h0, 1'b1);
        apb(32'hBFF8, 1'b1, 32'h0, 4'h0);

        // mtime wrap
        apb(32'hBFF8, 1'b1, 32'hFFFF_FFFF, 4'hF);
        apb(32'hBFFC, 1'b1, 32'hFFFF_FFFF, 4'hF);
        repeat (6) @(negedge pclk);
        apb(32'hBFF8, 1'b0, 0, 4'h0);
        apb(32'hBFFC, 1'b0, 0, 4'h0);

        // Software interrupt
        apb(32'h4, 1'b1, 32'h1, 4'hF);
        repeat (2) @(negedge pclk);
        apb(32'h4, 1'b0, 0, 4'h0);
        apb(32'h4, 1'b1, 32'h0, 4'hF);
        repeat (2) @(negedge pclk);

        // Randomised traffic; mtime writes land on tick edges now and then
        for (int i = 0; i < 250; i++) begin
            logic [31:0] o;
            logic [31:0] d;
            o = offs[$urandom_range(12, 0)];
            d = $urandom();
            if (o == 32'hBFFC && $urandom_range(3, 0) != 0) d = 32'h0;
            apb(o, 1'($urandom_range(1, 0)), d, 4'($urandom()));
            repeat ($urandom_range(3, 0)) @(negedge pclk);
        end

        // Reset during an access phase aborts the write
        @(negedge pclk);
        paddr = BASE + 32'h4000; pwrite = 1'b1; pdata = 32'h0; pstb = 4'hF;
        psel = 1'b1; penable = 1'b0;
        @(negedge pclk);
        penable = 1'b1;
        prst    = 1'b1;
        @(negedge pclk);
        prst = 1'b0; psel = 1'b0; penable = 1'b0;
        apb(32'h4000, 1'b0, 0, 4'h0);
        apb(32'h4004, 1'b0, 0, 4'h0);
        repeat (3) @(negedge pclk);

        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
